// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg : shared constants for the 4-digit scanned 7-segment driver
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam logic [1:0] DIG_US = 2'd0;
  localparam logic [1:0] DIG_DS = 2'd1;
  localparam logic [1:0] DIG_UM = 2'd2;
  localparam logic [1:0] DIG_DM = 2'd3;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Slot phase encoding
  localparam logic [0:0] APAGADO = 1'b0;
  localparam logic [0:0] MOSTRA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/varredura_display_if.sv
// ---------------------------------------------------------------------------
// varredura_display_if : digit patterns / blink requests in, scanned display out
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface varredura_display_if;
  logic [6:0] SEG_DM;
  logic [6:0] SEG_UM;
  logic [6:0] SEG_DS;
  logic [6:0] SEG_US;
  logic       BLINK_MIN;
  logic       BLINK_SEG;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic       DP;

  modport master (
    output SEG_DM, SEG_UM, SEG_DS, SEG_US, BLINK_MIN, BLINK_SEG,
    input  SEG, AN, DP
  );

  modport slave (
    input  SEG_DM, SEG_UM, SEG_DS, SEG_US, BLINK_MIN, BLINK_SEG,
    output SEG, AN, DP
  );
endinterface

`default_nettype wire

// File: rtl/contador_mod.sv
// ---------------------------------------------------------------------------
// contador_mod : mod-N counter with enable and terminal-count output
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module contador_mod #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_en,
  output logic [W-1:0]      o_cnt,
  output logic              o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(N - 1));
  assign o_tc   = i_en && w_last;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/varredura_display.sv
// ---------------------------------------------------------------------------
// varredura_display : time-multiplexed 4-digit 7-segment scanner with
// per-slot blanking and edit-mode field blinking
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module varredura_display
  import display_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK     = 500,
  parameter int BLINK_DIV = 64
) (
  input  wire logic          CLK,
  input  wire logic          RST,
  varredura_display_if.slave bus
);

  localparam int PW = (DIV > 1)       ? $clog2(DIV)       : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] w_p;
  logic [1:0]    w_idx;
  logic [FW-1:0] w_f;
  logic          w_tc_p;
  logic          w_tc_idx;
  logic          w_tc_f;
  logic          w_unused_f;

  contador_mod #(.N(DIV), .W(PW)) u_presc (
    .clk(CLK), .rst(RST), .i_en(1'b1), .o_cnt(w_p), .o_tc(w_tc_p)
  );

  contador_mod #(.N(4), .W(2)) u_digito (
    .clk(CLK), .rst(RST), .i_en(w_tc_p), .o_cnt(w_idx), .o_tc(w_tc_idx)
  );

  contador_mod #(.N(BLINK_DIV), .W(FW)) u_quadro (
    .clk(CLK), .rst(RST), .i_en(w_tc_idx), .o_cnt(w_f), .o_tc(w_tc_f)
  );

  assign w_unused_f = ^w_f;

  logic r_ph;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ph <= 1'b0;
    end else if (w_tc_f) begin
      r_ph <= ~r_ph;
    end
  end

  logic [6:0] w_pat_sel;
  logic       w_blk_sel;

  always_comb begin
    w_pat_sel = bus.SEG_US;
    w_blk_sel = bus.BLINK_SEG;
    case (w_idx)
      DIG_US: begin w_pat_sel = bus.SEG_US; w_blk_sel = bus.BLINK_SEG; end
      DIG_DS: begin w_pat_sel = bus.SEG_DS; w_blk_sel = bus.BLINK_SEG; end
      DIG_UM: begin w_pat_sel = bus.SEG_UM; w_blk_sel = bus.BLINK_MIN; end
      DIG_DM: begin w_pat_sel = bus.SEG_DM; w_blk_sel = bus.BLINK_MIN; end
      default: begin w_pat_sel = bus.SEG_US; w_blk_sel = bus.BLINK_SEG; end
    endcase
  end

  logic       w_cap;
  logic [6:0] r_hold;
  logic       r_blk;

  assign w_cap = (w_p == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold <= SEG_OFF;
      r_blk  <= 1'b0;
    end else if (w_cap) begin
      r_hold <= w_pat_sel;
      r_blk  <= w_blk_sel;
    end
  end

  // With BLANK=0 the slot is shown in the capture cycle itself, so the
  // freshly selected pattern bypasses the holding register there.
  logic [6:0] w_pat;
  logic       w_blk;

  assign w_pat = w_cap ? w_pat_sel : r_hold;
  assign w_blk = w_cap ? w_blk_sel : r_blk;

  logic w_apagado;

  generate
    if (BLANK > 0) begin : g_blank
      assign w_apagado = (w_p < PW'(BLANK));
    end else begin : g_no_blank
      assign w_apagado = 1'b0;
    end
  endgenerate

  logic [0:0] w_fase;

  assign w_fase = w_apagado ? APAGADO : MOSTRA;

  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b0;
    end else begin
      case (w_fase)
        MOSTRA: begin
          r_an <= ~(4'b0001 << w_idx);
          if (r_ph && w_blk) begin
            r_seg <= SEG_OFF;
            r_dp  <= 1'b0;
          end else begin
            r_seg <= w_pat;
            r_dp  <= (w_idx == DIG_UM);
          end
        end
        default: begin
          r_an  <= AN_OFF;
          r_seg <= SEG_OFF;
          r_dp  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.AN  = r_an;
  assign bus.SEG = r_seg;
  assign bus.DP  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_varredura_display.sv
// ---------------------------------------------------------------------------
// tb_varredura_display : directed bench for the scanned display driver
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_varredura_display;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  varredura_display_if ifa ();
  varredura_display_if ifb ();

  varredura_display #(.DIV(8), .BLANK(2), .BLINK_DIV(2)) dut_a (
    .CLK(clk), .RST(rst_a), .bus(ifa.slave)
  );

  varredura_display #(.DIV(4), .BLANK(0), .BLINK_DIV(64)) dut_b (
    .CLK(clk), .RST(rst_b), .bus(ifb.slave)
  );

  // Every cycle: at most one anode enabled, and a dark bus whenever all are off
  always @(negedge clk) begin
    n_assert++;
    assert (($countones(~ifa.AN) <= 1) && (ifa.AN != 4'hF || ifa.SEG == 7'h00))
    else begin
      n_fail++;
      $error("FAIL cont_a observed AN=%b SEG=%h expected <=1 low bit and dark SEG when off", ifa.AN, ifa.SEG);
    end
    n_assert++;
    assert (($countones(~ifb.AN) <= 1) && (ifb.AN != 4'hF || ifb.SEG == 7'h00))
    else begin
      n_fail++;
      $error("FAIL cont_b observed AN=%b SEG=%h expected <=1 low bit and dark SEG when off", ifb.AN, ifb.SEG);
    end
  end

  task automatic chk_a(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    n_assert++;
    assert ({ifa.AN, ifa.SEG, ifa.DP} === {an, seg, dp})
    else begin
      n_fail++;
      $error("FAIL %s observed AN/SEG/DP=%b/%h/%b expected %b/%h/%b",
             tag, ifa.AN, ifa.SEG, ifa.DP, an, seg, dp);
    end
  endtask

  task automatic run_a(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_a(tag, an, seg, dp);
    end
  endtask

  task automatic run_b(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_assert++;
      assert ({ifb.AN, ifb.SEG, ifb.DP} === {an, seg, dp})
      else begin
        n_fail++;
        $error("FAIL %s observed AN/SEG/DP=%b/%h/%b expected %b/%h/%b",
               tag, ifb.AN, ifb.SEG, ifb.DP, an, seg, dp);
      end
    end
  endtask

  initial begin
    ifa.SEG_DM = 7'h06; ifa.SEG_UM = 7'h5B; ifa.SEG_DS = 7'h4F; ifa.SEG_US = 7'h66;
    ifa.BLINK_MIN = 1'b0; ifa.BLINK_SEG = 1'b0;
    ifb.SEG_DM = 7'h06; ifb.SEG_UM = 7'h5B; ifb.SEG_DS = 7'h4F; ifb.SEG_US = 7'h66;
    ifb.BLINK_MIN = 1'b0; ifb.BLINK_SEG = 1'b0;

    repeat (3) @(negedge clk);
    chk_a("reset_a", 4'b1111, 7'h00, 1'b0);
    rst_a = 1'b0;

    // Frame 0: plain scan order
    run_a("f0_blank_us", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f0_us",       4'b1110, 7'h66, 1'b0, 6);
    run_a("f0_blank_ds", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f0_ds",       4'b1101, 7'h4F, 1'b0, 6);
    run_a("f0_blank_um", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f0_um",       4'b1011, 7'h5B, 1'b1, 6);
    run_a("f0_blank_dm", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f0_dm",       4'b0111, 7'h06, 1'b0, 6);

    // Frame 1: mid-slot change of US, blink requested but phase still 0
    run_a("f1_blank_us", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f1_us_pre",   4'b1110, 7'h66, 1'b0, 1);
    ifa.SEG_US    = 7'h3F;
    ifa.BLINK_MIN = 1'b1;
    run_a("f1_us_held",  4'b1110, 7'h66, 1'b0, 5);
    run_a("f1_blank_ds", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f1_ds",       4'b1101, 7'h4F, 1'b0, 6);
    run_a("f1_blank_um", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f1_um_ph0",   4'b1011, 7'h5B, 1'b1, 6);
    run_a("f1_blank_dm", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f1_dm_ph0",   4'b0111, 7'h06, 1'b0, 6);

    // Frame 2: blink phase 1, minutes dark, seconds unaffected
    run_a("f2_blank_us", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f2_us_new",   4'b1110, 7'h3F, 1'b0, 6);
    run_a("f2_blank_ds", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f2_ds",       4'b1101, 7'h4F, 1'b0, 6);
    run_a("f2_blank_um", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f2_um_blink", 4'b1011, 7'h00, 1'b0, 6);
    run_a("f2_blank_dm", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f2_dm_blink", 4'b0111, 7'h00, 1'b0, 6);

    // Frame 3: still blinking, reset while UM is being shown
    run_a("f3_blank_us", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f3_us",       4'b1110, 7'h3F, 1'b0, 6);
    run_a("f3_blank_ds", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f3_ds",       4'b1101, 7'h4F, 1'b0, 6);
    run_a("f3_blank_um", 4'b1111, 7'h00, 1'b0, 2);
    run_a("f3_um_blink", 4'b1011, 7'h00, 1'b0, 3);
    rst_a = 1'b1;
    run_a("midrst",      4'b1111, 7'h00, 1'b0, 1);
    rst_a = 1'b0;

    // Restart at US with blink phase cleared
    run_a("r_blank_us",  4'b1111, 7'h00, 1'b0, 2);
    run_a("r_us",        4'b1110, 7'h3F, 1'b0, 6);
    run_a("r_blank_ds",  4'b1111, 7'h00, 1'b0, 2);
    run_a("r_ds",        4'b1101, 7'h4F, 1'b0, 6);
    run_a("r_blank_um",  4'b1111, 7'h00, 1'b0, 2);
    run_a("r_um_ph0",    4'b1011, 7'h5B, 1'b1, 6);

    // No dead-time instance
    run_b("reset_b",     4'b1111, 7'h00, 1'b0, 1);
    rst_b = 1'b0;
    run_b("nb_us",       4'b1110, 7'h66, 1'b0, 4);
    run_b("nb_ds",       4'b1101, 7'h4F, 1'b0, 4);
    run_b("nb_um",       4'b1011, 7'h5B, 1'b1, 4);
    run_b("nb_dm",       4'b0111, 7'h06, 1'b0, 4);
    run_b("nb_us2",      4'b1110, 7'h66, 1'b0, 4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
